de2_115_timer_ticker: RTL and testbench

Hardware Avalon-MM master that drives the 16-bit interval-timer slave (s1) directly, with no CPU involvement. It programs the period, starts the timer in continuous interrupt mode and acknowledges each timeout. It turns the timer's level irq into a one-cycle `tick` strobe plus a free-running tick count. It sits upstream of the timer (owns its s1 port) and downstream of its irq, and feeds the painter's frame/animation logic.

---
 rtl/de2_115_timer_ticker_if.sv | 22 ++
 rtl/de2_115_timer_ticker.sv | 122 ++++++++++++
 tb/tb_de2_115_timer_ticker.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/de2_115_timer_ticker_if.sv
// Avalon-MM s1 port of the 16-bit interval timer plus its level interrupt.
interface de2_115_timer_ticker_if;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  logic [ADDR_W-1:0] tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [DATA_W-1:0] tmr_writedata;
  logic [DATA_W-1:0] tmr_readdata;
  logic              tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_readdata, tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_readdata, tmr_irq
  );
endinterface

// File: rtl/de2_115_timer_ticker.sv
// Autonomous Avalon master that programs the interval timer for periodic
// interrupts and converts each acknowledged timeout into a tick strobe.
module de2_115_timer_ticker #(
  parameter longint unsigned DEFAULT_PERIOD = 64'd50000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [31:0]                    cfg_period,
  input  logic                           cfg_load,
  de2_115_timer_ticker_if.master         s1,
  output logic                           tick,
  output logic [31:0]                    tick_count,
  output logic                           busy,
  output logic                           err
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;
  localparam logic [CNT_W-1:0]  DEFAULT_LOAD = CNT_W'(DEFAULT_PERIOD - 64'd1);
  localparam logic [ADDR_W-1:0] A_STATUS  = 3'd0;
  localparam logic [ADDR_W-1:0] A_CONTROL = 3'd1;
  localparam logic [ADDR_W-1:0] A_PERIODL = 3'd2;
  localparam logic [ADDR_W-1:0] A_PERIODH = 3'd3;
  localparam logic [DATA_W-1:0] CTRL_STOP = 16'h0008;
  localparam logic [DATA_W-1:0] CTRL_GO   = 16'h0007;

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_PL, S_PH, S_RDPL, S_CHK, S_CTRL, S_RUN, S_ACK, S_OFF, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  load_q;     // latched L = P-1
  logic [CNT_W-1:0]  prog_q;     // L being written in the current pass
  logic              pend_q;
  logic [CNT_W-1:0]  load_new_c;
  logic [CNT_W-1:0]  load_eff_c;
  logic              cs_d, wn_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wd_d;

  // Clamp periods below 2 and convert to a load value; a strobe on the
  // same cycle STOP is entered must be used by that very pass.
  always_comb begin
    load_new_c = (cfg_period < 32'd2) ? 32'd1 : cfg_period - 32'd1;
    load_eff_c = cfg_load ? load_new_c : load_q;
  end

  // Next state and the bus cycle the next state will drive
  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = '0;
    wd_d    = '0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_STOP;
      S_STOP: state_d = S_PL;
      S_PL:   state_d = S_PH;
      S_PH:   state_d = S_RDPL;
      S_RDPL: state_d = S_CHK;
      S_CHK:  state_d = (s1.tmr_readdata != prog_q[15:0]) ? S_HALT : S_CTRL;
      S_CTRL: state_d = S_RUN;
      S_RUN: begin
        if (!enable)                 state_d = S_OFF;
        else if (pend_q || cfg_load) state_d = S_STOP;
        else if (s1.tmr_irq)         state_d = S_ACK;
      end
      S_ACK:  state_d = S_RUN;
      S_OFF:  state_d = S_IDLE;
      S_HALT: if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_STOP, S_OFF: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL; wd_d = CTRL_STOP; end
      S_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIODL; wd_d = prog_q[15:0]; end
      S_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIODH; wd_d = prog_q[31:16]; end
      S_RDPL, S_CHK: begin cs_d = 1'b1; addr_d = A_PERIODL; end
      S_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL; wd_d = CTRL_GO; end
      S_ACK:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = A_STATUS; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      load_q            <= DEFAULT_LOAD;
      prog_q            <= DEFAULT_LOAD;
      pend_q            <= 1'b0;
      tick              <= 1'b0;
      tick_count        <= '0;
      busy              <= 1'b0;
      err               <= 1'b0;
      s1.tmr_chipselect <= 1'b0;
      s1.tmr_write_n    <= 1'b1;
      s1.tmr_address    <= '0;
      s1.tmr_writedata  <= '0;
    end else begin
      state_q           <= state_d;
      s1.tmr_chipselect <= cs_d;
      s1.tmr_write_n    <= wn_d;
      s1.tmr_address    <= addr_d;
      s1.tmr_writedata  <= wd_d;
      tick              <= (state_d == S_ACK);
      busy              <= (state_d inside {S_STOP, S_PL, S_PH, S_RDPL, S_CHK, S_CTRL});
      if (cfg_load) load_q <= load_new_c;
      if (state_d == S_STOP) begin
        pend_q <= 1'b0;
        prog_q <= load_eff_c;
      end else if (cfg_load) begin
        pend_q <= 1'b1;
      end
      if (state_d == S_ACK) tick_count <= tick_count + 32'd1;
      if (state_d == S_STOP) err <= 1'b0;
      else if (state_q == S_CHK && state_d == S_HALT) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_de2_115_timer_ticker.sv
// Bench for de2_115_timer_ticker: behavioural interval-timer slave, bus
// transaction log, per-cycle invariant checks and directed scenarios.
module tb_de2_115_timer_ticker;
  localparam int unsigned P_DEF = 50000;
  localparam logic [19:0] RD2 = {1'b0, 3'd2, 16'h0000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        tick, busy, err;
  logic [31:0] tick_count;

  de2_115_timer_ticker_if s1();

  de2_115_timer_ticker #(.DEFAULT_PERIOD(P_DEF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_period(cfg_period),
    .cfg_load(cfg_load), .s1(s1), .tick(tick), .tick_count(tick_count),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Interval timer slave: period regs at 2/3, control at 1, status at 0.
  logic [15:0] t_per_l = '0, t_per_h = '0, t_ctrl = '0, t_rd = '0;
  logic [31:0] t_cnt = '0;
  logic        t_run = 1'b0, t_to = 1'b0;
  logic        corrupt = 1'b0, irq_force = 1'b0;

  assign s1.tmr_readdata = t_rd;
  assign s1.tmr_irq      = (t_to & t_ctrl[0]) | irq_force;

  always @(posedge clk) begin
    if (s1.tmr_chipselect && !s1.tmr_write_n) begin
      case (s1.tmr_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ctrl <= s1.tmr_writedata;
          if (s1.tmr_writedata[3]) t_run <= 1'b0;
          else if (s1.tmr_writedata[2]) t_run <= 1'b1;
        end
        3'd2: begin t_per_l <= s1.tmr_writedata; t_cnt <= {t_per_h, s1.tmr_writedata}; end
        3'd3: begin t_per_h <= s1.tmr_writedata; t_cnt <= {s1.tmr_writedata, t_per_l}; end
        default: ;
      endcase
    end
    if (t_run) begin
      if (t_cnt == 32'd0) begin t_to <= 1'b1; t_cnt <= {t_per_h, t_per_l}; end
      else t_cnt <= t_cnt - 32'd1;
    end
    if (s1.tmr_chipselect && s1.tmr_write_n) begin
      case (s1.tmr_address)
        3'd1: t_rd <= t_ctrl;
        3'd2: t_rd <= corrupt ? 16'hDEAD : t_per_l;
        3'd3: t_rd <= t_per_h;
        default: t_rd <= {15'd0, t_to};
      endcase
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: tick count model, tick shape, idle bus, transaction log
  logic        mon_en = 1'b0;
  logic [31:0] cnt_preset = '0;
  logic [31:0] model_cnt = '0;
  logic        prev_tick = 1'b0;
  logic [19:0] log_q[$];

  always @(negedge clk) begin
    if (!mon_en) begin
      model_cnt = cnt_preset;
    end else begin
      if (tick) model_cnt = model_cnt + 32'd1;
      check("tick_count", tick_count, model_cnt);
      if (tick) begin
        check("tick_consecutive", 32'(prev_tick), 32'd0);
        check("tick_bus", 32'({s1.tmr_chipselect, s1.tmr_write_n, s1.tmr_address, s1.tmr_writedata}),
              32'({1'b1, 1'b0, 3'd0, 16'h0000}));
      end
      if (!s1.tmr_chipselect)
        check("idle_bus", 32'({s1.tmr_write_n, s1.tmr_address, s1.tmr_writedata}),
              32'({1'b1, 3'd0, 16'h0000}));
    end
    prev_tick = tick;
    if (s1.tmr_chipselect === 1'b1)
      log_q.push_back({~s1.tmr_write_n, s1.tmr_address, s1.tmr_writedata});
  end

  function automatic logic [19:0] bw(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [19:0] exp);
    if (idx < log_q.size()) check(name, 32'(log_q[idx]), 32'(exp));
    else check({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
  endtask

  task automatic wait_write(input string name, input logic [2:0] a, input logic [15:0] d,
                            input int budget);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = s1.tmr_chipselect && !s1.tmr_write_n && s1.tmr_address == a && s1.tmr_writedata == d;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_tick(input string name, input int budget, output int n);
    n = 0;
    do begin step(); n++; end while (!tick && n < budget);
    check(name, 32'(tick), 32'd1);
  endtask

  task automatic apply_cfg(input logic [31:0] p);
    cfg_period = p;
    cfg_load   = 1'b1;
    step();
    cfg_load   = 1'b0;
  endtask

  task automatic spacing(input string name, input int p, input int reps);
    int n;
    for (int i = 0; i < reps; i++) begin
      wait_tick(name, p + 10, n);
      check(name, 32'(n), 32'(p));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int mark, n, cnt;

    // Reset values
    repeat (3) step();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_count", tick_count, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bus", 32'({s1.tmr_chipselect, s1.tmr_write_n, s1.tmr_address, s1.tmr_writedata}),
          32'({1'b0, 1'b1, 3'd0, 16'h0000}));
    reset  = 1'b0;
    mon_en = 1'b1;

    // Default period: programming trace and first tick window
    mark = log_q.size();
    enable = 1'b1;
    wait_write("def_ctrl", 3'd1, 16'h0007, 20);
    wait_tick("def_first_tick", P_DEF + 10, n);
    check("def_first_window", 32'(n >= P_DEF + 1 && n <= P_DEF + 3), 32'd1);
    check("def_count1", tick_count, 32'd1);
    chk_log("def_stop", mark + 0, bw(3'd1, 16'h0008));
    chk_log("def_pl",   mark + 1, bw(3'd2, 16'hC34F));
    chk_log("def_ph",   mark + 2, bw(3'd3, 16'h0000));
    chk_log("def_rd",   mark + 3, RD2);
    chk_log("def_rd2",  mark + 4, RD2);
    chk_log("def_go",   mark + 5, bw(3'd1, 16'h0007));
    chk_log("def_ack",  mark + 6, bw(3'd0, 16'h0000));

    // Reprogram to 0x12345 from RUN: busy window and written halves
    mark = log_q.size();
    cnt = 0;
    cfg_period = 32'h0001_2345;
    cfg_load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      cfg_load = 1'b0;
      if (busy) cnt++;
    end
    check("busy_cycles", 32'(cnt), 32'd6);
    chk_log("p12345_stop", mark + 0, bw(3'd1, 16'h0008));
    chk_log("p12345_pl",   mark + 1, bw(3'd2, 16'h2344));
    chk_log("p12345_ph",   mark + 2, bw(3'd3, 16'h0001));
    chk_log("p12345_rd",   mark + 3, RD2);
    chk_log("p12345_go",   mark + 5, bw(3'd1, 16'h0007));

    // Steady-state spacing at P=20
    apply_cfg(32'd20);
    wait_write("p20_ctrl", 3'd1, 16'h0007, 20);
    wait_tick("p20_first", 40, n);
    spacing("p20_spacing", 20, 3);

    // P=1 and P=0 clamp to 2: tick every other cycle
    mark = log_q.size();
    apply_cfg(32'd1);
    wait_write("p1_ctrl", 3'd1, 16'h0007, 20);
    chk_log("p1_pl", mark + 1, bw(3'd2, 16'h0001));
    chk_log("p1_ph", mark + 2, bw(3'd3, 16'h0000));
    wait_tick("p1_first", 20, n);
    spacing("p1_spacing", 2, 3);
    mark = log_q.size();
    apply_cfg(32'd0);
    wait_write("p0_ctrl", 3'd1, 16'h0007, 20);
    chk_log("p0_pl", mark + 1, bw(3'd2, 16'h0001));
    chk_log("p0_ph", mark + 2, bw(3'd3, 16'h0000));
    wait_tick("p0_first", 20, n);
    spacing("p0_spacing", 2, 3);

    // cfg_load and irq together in RUN: reprogram wins, no tick
    apply_cfg(32'd1000);
    wait_write("p1000_ctrl", 3'd1, 16'h0007, 20);
    repeat (20) step();
    check("clash_pre_busy", 32'(busy), 32'd0);
    mark = log_q.size();
    cfg_period = 32'd1000;
    cfg_load = 1'b1;
    irq_force = 1'b1;
    step();
    cfg_load = 1'b0;
    irq_force = 1'b0;
    check("clash_no_tick", 32'(tick), 32'd0);
    check("clash_busy", 32'(busy), 32'd1);
    chk_log("clash_stop", mark, bw(3'd1, 16'h0008));
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (tick) cnt++; end
    check("clash_ticks", 32'(cnt), 32'd0);

    // enable dropped in RUN: one stop write, then silence
    repeat (20) step();
    mark = log_q.size();
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(); if (tick) cnt++; end
    check("off_ticks", 32'(cnt), 32'd0);
    check("off_writes", 32'(log_q.size() - mark), 32'd1);
    chk_log("off_stop", mark, bw(3'd1, 16'h0008));
    check("off_busy", 32'(busy), 32'd0);

    // Corrupted readback: err, no CTRL write, stays halted
    corrupt = 1'b1;
    mark = log_q.size();
    enable = 1'b1;
    repeat (30) step();
    check("halt_err", 32'(err), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_entries", 32'(log_q.size() - mark), 32'd5);
    chk_log("halt_pl", mark + 1, bw(3'd2, 16'h03E7));
    chk_log("halt_rd", mark + 4, RD2);
    enable = 1'b0;
    repeat (3) step();
    check("halt_err_sticky", 32'(err), 32'd1);
    corrupt = 1'b0;
    mark = log_q.size();
    enable = 1'b1;
    wait_write("rearm_ctrl", 3'd1, 16'h0007, 20);
    check("rearm_err", 32'(err), 32'd0);
    chk_log("rearm_stop", mark, bw(3'd1, 16'h0008));

    // tick_count wrap
    wait_tick("wrap_pre", 1010, n);
    mon_en = 1'b0;
    cnt_preset = 32'hFFFF_FFFF;
    force dut.tick_count = 32'hFFFF_FFFF;
    step();
    release dut.tick_count;
    mon_en = 1'b1;
    wait_tick("wrap_tick", 1010, n);
    check("wrap_count", tick_count, 32'd0);

    // Reset asserted during PH
    apply_cfg(32'd20);
    wait_write("rst_ph_seen", 3'd3, 16'h0000, 20);
    mon_en = 1'b0;
    cnt_preset = 32'd0;
    reset = 1'b1;
    step();
    check("rph_bus", 32'({s1.tmr_chipselect, s1.tmr_write_n, s1.tmr_address, s1.tmr_writedata}),
          32'({1'b0, 1'b1, 3'd0, 16'h0000}));
    check("rph_tick", 32'(tick), 32'd0);
    check("rph_count", tick_count, 32'd0);
    check("rph_busy", 32'(busy), 32'd0);
    check("rph_err", 32'(err), 32'd0);
    reset = 1'b0;
    mark = log_q.size();
    repeat (3) step();
    mon_en = 1'b1;
    chk_log("rph_restart", mark, bw(3'd1, 16'h0008));
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
